// File: rtl/handshake_monitor_pkg.sv
// Shared types and default constants for the handshake monitor.
//   hs_mon_state_t          : per-channel supervisor state
//   DEFAULT_TIMEOUT_CYCLES  : default stuck-line timeout in clk cycles
//   DEFAULT_BLINK_HALF      : default half-period of the fault blink in clk cycles
package types;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FAULT
    } hs_mon_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50_000_000;
    localparam int unsigned DEFAULT_BLINK_HALF     = 12_500_000;

endpackage

// File: rtl/hs_channel_fsm.sv
// One supervised handshake channel: 2-flop synchroniser, stuck-line timeout counter
// and IDLE/ACTIVE/FAULT state machine.
//   clk           : system clock
//   reset         : asynchronous active-high reset
//   handshake_in  : raw asynchronous handshake line (active-high)
//   clear_faults  : single-cycle pulse that releases the FAULT state
//   state         : registered channel state
//   hs_s          : synchronised handshake line
module hs_channel_fsm
    import types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          handshake_in,
    input  logic          clear_faults,
    output hs_mon_state_t state,
    output logic          hs_s
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic            sync_q;
    logic            hs_s_q;
    hs_mon_state_t   state_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 1'b0;
            hs_s_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q <= handshake_in;
            hs_s_q <= sync_q;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (hs_s_q) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!hs_s_q) begin
                        // Deassertion wins over a coincident timeout.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        // A coincident clear restarts the timeout instead of faulting.
                        cnt_q <= '0;
                        if (!clear_faults) begin
                            state_q <= FAULT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                FAULT: begin
                    cnt_q <= '0;
                    if (clear_faults) begin
                        state_q <= hs_s_q ? ACTIVE : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state = state_q;
    assign hs_s  = hs_s_q;

endmodule

// File: rtl/handshake_monitor.sv
// Supervisor for NUM_CHAN handshake lines: flags any line held asserted longer than
// TIMEOUT_CYCLES, latches per-channel faults and drives active-low status LEDs.
//   clk           : system clock
//   reset         : asynchronous active-high reset
//   handshake_in  : raw asynchronous handshake lines (tri-stated lines read as 1)
//   led_mode      : 0 = live mirror of the synchronised lines, 1 = status display
//   clear_faults  : single-cycle pulse clearing all latched faults
//   led_n         : registered active-low LED drives
//   fault         : registered per-channel stuck-line fault
//   any_fault     : registered OR of fault
module handshake_monitor
    import types::*;
#(
    parameter int unsigned NUM_CHAN       = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned BLINK_HALF     = DEFAULT_BLINK_HALF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CHAN-1:0] handshake_in,
    input  logic                led_mode,
    input  logic                clear_faults,
    output logic [NUM_CHAN-1:0] led_n,
    output logic [NUM_CHAN-1:0] fault,
    output logic                any_fault
);

    localparam int unsigned     DivW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(BLINK_HALF - 1);

    hs_mon_state_t       state [NUM_CHAN];
    logic [NUM_CHAN-1:0] hs_s;

    logic [DivW-1:0]     div_q;
    logic                blink_q;
    logic [NUM_CHAN-1:0] led_n_d;
    logic [NUM_CHAN-1:0] fault_d;
    logic [NUM_CHAN-1:0] led_n_q;
    logic [NUM_CHAN-1:0] fault_q;
    logic                any_fault_q;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        hs_channel_fsm #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .handshake_in (handshake_in[i]),
            .clear_faults (clear_faults),
            .state        (state[i]),
            .hs_s         (hs_s[i])
        );
    end

    always_comb begin
        led_n_d = '1;
        fault_d = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            fault_d[i] = (state[i] == FAULT);
            if (!led_mode) begin
                led_n_d[i] = ~hs_s[i];
            end else begin
                case (state[i])
                    IDLE:    led_n_d[i] = 1'b1;
                    ACTIVE:  led_n_d[i] = 1'b0;
                    FAULT:   led_n_d[i] = ~blink_q;
                    default: led_n_d[i] = 1'b1;
                endcase
            end
        end
    end

    // Free-running blink divider shared by all channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            blink_q <= 1'b0;
        end else if (div_q == DivMax) begin
            div_q   <= '0;
            blink_q <= ~blink_q;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_n_q     <= '1;
            fault_q     <= '0;
            any_fault_q <= 1'b0;
        end else begin
            led_n_q     <= led_n_d;
            fault_q     <= fault_d;
            any_fault_q <= |fault_d;
        end
    end

    assign led_n     = led_n_q;
    assign fault     = fault_q;
    assign any_fault = any_fault_q;

endmodule

// File: doc/handshake_monitor.md
# handshake_monitor

Parametrised supervisor that watches `NUM_CHAN` handshake lines (µP and bus handshakes), detects any line held asserted longer than `TIMEOUT_CYCLES`, latches a per-channel fault and drives active-low status LEDs. It sits at the top level beside the bus interface and succeeds the fixed four-LED mirror. It adds synchronisation, stuck-line detection, fault latching and a blink-coded status mode.

## Interface
- `NUM_CHAN`, 4: number of monitored handshake lines and LEDs.
- `TIMEOUT_CYCLES`, 50_000_000: maximum allowed continuous assertion of a line, in clk cycles, ≥2.
- `BLINK_HALF`, 12_500_000: clk cycles per half-period of the fault blink, ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `handshake_in`  in  NUM_CHAN  raw asynchronous handshake lines, active-high. Tri-stated lines read as 1.
- `led_mode`  in  1  0 = live mirror; 1 = status display.
- `clear_faults`  in  1  synchronous single-cycle pulse that clears all latched faults.
- `led_n`  out  NUM_CHAN  active-low LED drives.
- `fault`  out  NUM_CHAN  latched per-channel stuck-line fault.
- `any_fault`  out  1  OR of `fault`.

## Operation
- Each line passes through a 2-flop synchroniser, giving `hs_s[i]`.
- There is one FSM per channel, with states IDLE, ACTIVE and FAULT. Each channel also has a counter `cnt[i]` of width `$clog2(TIMEOUT_CYCLES)`.
  - IDLE: `cnt` = 0. If `hs_s` = 1, go to ACTIVE.
  - ACTIVE: `cnt` increments each cycle.
    - If `hs_s` = 0, go to IDLE and set `cnt` to 0.
    - Else if `cnt == TIMEOUT_CYCLES-1`, go to FAULT.
  - FAULT: `fault[i]` = 1 and `cnt` is held at 0. The state is left only via `clear_faults`.
    - If `hs_s` = 0, go to IDLE.
    - If `hs_s` = 1, go to ACTIVE with `cnt` = 0, which restarts the timeout.
- `clear_faults` has no effect in IDLE or ACTIVE.
- Simultaneous events:
  - `clear_faults` in the same cycle that ACTIVE would enter FAULT: the clear wins. `cnt` is set to 0 and the channel stays ACTIVE.
  - Deassertion in the same cycle as the timeout: the deassertion wins and the channel goes to IDLE.
- A shared blink divider counts 0..`BLINK_HALF`-1 and toggles `blink` on wrap. It is free-running from reset.
- LED output:
  - `led_mode` = 0: `led_n[i] = ~hs_s[i]`. A tri-stated line therefore shows ON.
  - `led_mode` = 1: IDLE gives `led_n` = 1, ACTIVE gives 0, FAULT gives `~blink`.
- `fault` and `any_fault` are independent of `led_mode`.

## Timing
- Reset values (asynchronous): synchronisers 0, all FSMs IDLE, `cnt` 0, `blink` 0, divider 0, `led_n` all 1, `fault` 0, `any_fault` 0.
- All outputs are registered. `led_n`, `fault` and `any_fault` each come from a flop.
- Input to LED latency in mode 0 is 3 cycles: 2 synchroniser cycles plus 1 output register.
- FSM latency:
  - ACTIVE is entered 1 cycle after `hs_s` rises.
  - FAULT is entered exactly `TIMEOUT_CYCLES` cycles after ACTIVE is entered.
  - `fault` rises 1 cycle after that.
  - From a clean rising edge on `handshake_in` to `fault`: `TIMEOUT_CYCLES`+4 cycles.
- A pulse of length ≥ 3 cycles in `hs_s` that stays below the timeout never faults. A deassertion of ≥ 1 synced cycle fully restarts the count.
- `clear_faults` is sampled on the clock edge. `fault` falls 1 cycle after the edge that clears.
- Reset asserted mid-count or in FAULT returns every channel to IDLE immediately. No fault survives reset.
- `led_mode` may change on any cycle. The new mapping is visible 1 cycle later.

## Structure
- Package `types`: `hs_mon_state_t` enum {IDLE, ACTIVE, FAULT}, plus the default timeout and blink constants. These may be defined in `global_constants.sv` and referenced by the package.
- Sub-module `hs_channel_fsm`:
  - Contains the synchroniser, FSM and counter for one channel.
  - Parameter: `TIMEOUT_CYCLES`.
  - Outputs: state, `hs_s`.
  - Instantiated `NUM_CHAN` times via a generate loop.
- The top level holds the blink divider and the LED/fault output registers.

## Test plan
All scenarios use `NUM_CHAN`=4, `TIMEOUT_CYCLES`=8, `BLINK_HALF`=2.
- Reset mid-operation:
  - Stimulus: drive ch0 high for 20 cycles, assert `reset` for 1 cycle at cycle 10.
  - Response: all outputs return to reset values immediately. After release, `fault[0]` rises at cycle 8+4 measured from release.
- Stuck line:
  - Stimulus: hold ch1 = 1.
  - Response: `fault` = 4'b0010 and `any_fault` = 1 exactly 12 cycles after the rising edge. In mode 1, `led_n[1]` toggles every 2 cycles.
- Short pulses:
  - Stimulus: ch2 high for 7 cycles, low for 1, high for 7, repeated 5 times.
  - Response: `fault` stays 0. In mode 1, `led_n[2]` tracks ACTIVE/IDLE.
- Clear with line still high:
  - Stimulus: ch3 faulted and held high, pulse `clear_faults`.
  - Response: `fault[3]` falls next cycle, then re-asserts 9 cycles after the clear edge (8 counting + 1 register).
- Clear versus timeout collision:
  - Stimulus: pulse `clear_faults` on the cycle where ch0 `cnt` = 7.
  - Response: no fault, and the count restarts.
- Mode 0 mirror:
  - Stimulus: `handshake_in` = 4'b1010.
  - Response: `led_n` = 4'b0101 3 cycles later, regardless of fault state.
